// File: rtl/theta_mix.sv
// theta_mix: Keccak theta second half, one 25-bit slice written per cycle after a start handshake.
// Optional THETA_MIX_OUTREG_EN registers the write port and adds a FLUSH state.
module theta_mix #(
    parameter int SLICES = 64,
    parameter int AW     = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ready,
    output logic [AW-1:0] par_addr,
    input  logic [4:0]    par_data,
    output logic [AW-1:0] st_addr,
    input  logic [24:0]   st_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [24:0]   wr_data
);

`ifdef THETA_MIX_OUTREG_EN
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_WAIT = 3'd1, S_PRE = 3'd2, S_RUN = 3'd3,
                              S_FLUSH = 3'd4} state_t;
`else
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_WAIT = 3'd1, S_PRE = 3'd2, S_RUN = 3'd3} state_t;
`endif

    localparam logic [AW-1:0] LAST = AW'(SLICES - 1);

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt;
    logic [4:0]      prev;
    logic [4:0]      d;
    logic            wr_en_c;
    logic [AW-1:0]   wr_addr_c;
    logic [24:0]     wr_data_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            prev  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_PRE) begin
                prev <= par_data;
                cnt  <= '0;
            end else if (state == S_RUN) begin
                prev <= par_data;
                cnt  <= cnt + 1'b1;
            end
        end
    end

    // D[x] = C[x-1][z] ^ C[x+1][z-1]; prev carries C[.][z-1]
    always_comb begin
        d = '0;
        for (int x = 0; x < 5; x++)
            d[x] = par_data[(x + 4) % 5] ^ prev[(x + 1) % 5];
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        par_addr  = '0;
        st_addr   = '0;
        wr_en_c   = 1'b0;
        wr_addr_c = '0;
        wr_data_c = '0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!start) state_nxt = S_PRE;
            end
            S_PRE: begin
                par_addr  = LAST;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                par_addr  = cnt;
                st_addr   = cnt;
                wr_en_c   = 1'b1;
                wr_addr_c = cnt;
                wr_data_c = st_data ^ {5{d}};
                if (cnt == LAST) begin
`ifdef THETA_MIX_OUTREG_EN
                    state_nxt = S_FLUSH;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
`ifdef THETA_MIX_OUTREG_EN
            S_FLUSH: state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef THETA_MIX_OUTREG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en   <= wr_en_c;
            wr_addr <= wr_addr_c;
            wr_data <= wr_data_c;
        end
    end
`else
    assign wr_en   = wr_en_c;
    assign wr_addr = wr_addr_c;
    assign wr_data = wr_data_c;
`endif

endmodule

// File: tb/tb_theta_mix.sv
// Randomised and directed bench for theta_mix against a slice-level theta model.
module tb_theta_mix;
    localparam int SLICES = 64;
    localparam int AW     = 6;
`ifdef THETA_MIX_OUTREG_EN
    localparam int OR = 1;
`else
    localparam int OR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ready;
    logic [AW-1:0] par_addr;
    logic [4:0]    par_data;
    logic [AW-1:0] st_addr;
    logic [24:0]   st_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [24:0]   wr_data;

    logic [4:0]  par_mem [SLICES];
    logic [24:0] st_mem  [SLICES];
    logic [24:0] exp_mem [SLICES];
    logic [24:0] got     [SLICES];

    int errors = 0;
    int checks = 0;

    theta_mix #(.SLICES(SLICES), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .par_addr(par_addr), .par_data(par_data),
        .st_addr(st_addr), .st_data(st_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    assign par_data = par_mem[par_addr];
    assign st_data  = st_mem[st_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: out[z] bit 5y+x = S[z] ^ C[x-1][z] ^ C[x+1][z-1]
    task automatic compute_exp();
        for (int z = 0; z < SLICES; z++) begin
            for (int y = 0; y < 5; y++) begin
                for (int x = 0; x < 5; x++) begin
                    logic [4:0] cz, cm;
                    cz = par_mem[z];
                    cm = par_mem[(z + SLICES - 1) % SLICES];
                    exp_mem[z][5*y+x] = st_mem[z][5*y+x] ^ cz[(x + 4) % 5] ^ cm[(x + 1) % 5];
                end
            end
            got[z] = 'x;
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < SLICES; i++) begin
            par_mem[i] = (mode == 1) ? 5'($urandom) : 5'd0;
            st_mem[i]  = (mode == 1) ? 25'($urandom) : ((mode == 2) ? 25'h1FFFFFF : 25'd0);
        end
    endtask

    // Caller is at #1 after a rising edge. rst_after<0 means run to completion.
    task automatic run_op(input int hold, input int rst_after, input bit mid_pulse);
        int lowcnt = 0;
        int nwr = 0;
        bit done = 0;
        compute_exp();
        start = 1'b1;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == hold - 1) start = 1'b0;
            if (mid_pulse && lowcnt == 20) start = 1'b1;
            if (mid_pulse && lowcnt == 21) start = 1'b0;
            if (rst_after >= 0 && nwr == rst_after) begin
                rst = 1'b1;
                #1;
                chk("rst_wr_en", 32'(wr_en), 32'd0);
                chk("rst_ready", 32'(ready), 32'd1);
                chk("rst_nwr", nwr, rst_after);
                chk("rst_lowcnt", lowcnt, hold + 1 + rst_after + OR);
                @(posedge clk);
                #1;
                rst = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    chk("post_rst_idle", {31'd0, ready & ~wr_en}, 32'd1);
                end
                return;
            end
            if (ready) begin
                done = 1;
            end else begin
                lowcnt++;
                if (lowcnt <= hold)
                    chk("wait_no_write", 32'(wr_en), 32'd0);
                if (lowcnt == hold + 1)
                    chk("pre_par_addr", 32'(par_addr), SLICES - 1);
                if (wr_en) begin
                    chk("wr_addr", 32'(wr_addr), nwr);
                    chk("wr_data", 32'(wr_data), 32'(exp_mem[nwr % SLICES]));
                    got[wr_addr] = wr_data;
                    if (nwr == 0) chk("first_write_cycle", lowcnt, hold + 2 + OR);
                    nwr++;
                end
            end
        end
        if (!done) chk("timeout_ready", 32'(ready), 32'd1);
        chk("ready_low_cycles", lowcnt, hold + 1 + SLICES + OR);
        chk("write_count", nwr, SLICES);
        chk("idle_wr_en", 32'(wr_en), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fill(0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_wr_addr", 32'(wr_addr), 32'd0);
        chk("reset_wr_data", 32'(wr_data), 32'd0);
        chk("reset_par_addr", 32'(par_addr), 32'd0);
        chk("reset_st_addr", 32'(st_addr), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // all-zero memories
        run_op(1, -1, 0);
        chk("zero_slice40", 32'(got[40]), 32'd0);

        // parity[63] = 00010 feeds slice 0 through the wrap
        fill(0);
        par_mem[63] = 5'b00010;
        run_op(1, -1, 0);
        chk("p63_slice0", 32'(got[0]), 32'h0108421);
        chk("p63_slice63", 32'(got[63]), 32'h0421084);
        chk("p63_slice1", 32'(got[1]), 32'd0);

        // parity[5] = 00001
        fill(0);
        par_mem[5] = 5'b00001;
        run_op(1, -1, 0);
        chk("p5_slice5", 32'(got[5]), 32'h0210842);
        chk("p5_slice6", 32'(got[6]), 32'h1084210);
        chk("p5_slice7", 32'(got[7]), 32'd0);

        // state all ones, parity zero
        fill(2);
        run_op(1, -1, 0);
        chk("ones_slice17", 32'(got[17]), 32'h1FFFFFF);

        // random contents, varied start hold and a stray start during RUN
        for (int r = 0; r < 3; r++) begin
            fill(1);
            run_op(1 + r, -1, r == 1);
        end

        // start held 3 cycles, reset after 10 writes
        fill(1);
        run_op(3, 10, 0);

        // operation after a mid-run reset starts cleanly
        fill(1);
        run_op(2, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
